ber_test_ctrl: RTL and testbench

Sequencer for one BER measurement run: owns reset/enable of the wide PRBS pattern generator and resync of the downstream pattern checker, waits for checker lock, then accumulates bit and error counts over a programmable word window. Sits between the register/host interface (start, window, results) and the generator/checker pair in the BER tester datapath.

---
 rtl/ber_pkg.sv | 20 ++
 rtl/popcount.sv | 20 ++
 rtl/ber_test_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ber_test_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// ber_pkg: shared definitions for the BER tester datapath.
// Holds the run-sequencer state encoding and the default word / counter
// widths that the generator, checker and sequencer agree on.
package ber_pkg;

    // Run sequencer states, in the order a normal run visits them.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_ACQ  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } ber_state_e;

    localparam int BER_WIDTH   = 32;    // PRBS word width
    localparam int BER_CNT_W   = 48;    // bit / error accumulator width
    localparam int BER_WIN_W   = 32;    // window length width (words)
    localparam int BER_LOCK_TO = 1024;  // ACQ cycles before lock timeout

endpackage

// File: rtl/popcount.sv
// popcount: purely combinational count of set bits in a vector.
// Ports:
//   vec   in  WIDTH                 vector to count
//   count out clog2(WIDTH+1)        number of ones in vec
module popcount #(
    parameter int WIDTH = 32,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + OUT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// ber_test_ctrl: sequencer for one BER measurement run.
// Holds the PRBS generator in reset while idle, resyncs the checker, waits
// for checker lock, then accumulates bit and errored-bit counts over a
// programmable window of compared words.
//
// Handshake: the checker side is valid-only. A word is consumed on every
// clk edge where chk_valid=1, the sequencer is in RUN and chk_locked=1;
// there is no back-pressure. start/abort are single-cycle level requests.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, abort               run control from the host
//   win_words [WIN_W]          window length in words (0 = until abort)
//   chk_locked, chk_valid      checker status
//   chk_err [WIDTH]            per-bit mismatch vector
//   gen_reset, gen_en          generator control
//   chk_resync                 checker resync request
//   busy, done                 run status (done is a 1-cycle pulse)
//   timeout, lock_lost         sticky end-of-run reasons
//   bit_count, err_count [CNT_W] results (err_count saturates)
//   state_dbg                  current sequencer state, for observation
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int WIDTH   = BER_WIDTH,
    parameter int CNT_W   = BER_CNT_W,
    parameter int WIN_W   = BER_WIN_W,
    parameter int LOCK_TO = BER_LOCK_TO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_words,
    input  logic             chk_locked,
    input  logic             chk_valid,
    input  logic [WIDTH-1:0] chk_err,
    output logic             gen_reset,
    output logic             gen_en,
    output logic             chk_resync,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             lock_lost,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output ber_state_e       state_dbg
);

    localparam int PC_W = $clog2(WIDTH + 1);
    localparam int LT_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

    ber_state_e       state, state_nxt;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] word_cnt;
    logic [LT_W-1:0]  lock_timer;
    logic [PC_W-1:0]  err_bits;
    logic [CNT_W:0]   err_wide;
    logic [CNT_W-1:0] err_sum;
    logic             start_ok;
    logic             word_ok;
    logic             set_timeout;
    logic             set_lock_lost;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec   (chk_err),
        .count (err_bits)
    );

    assign start_ok = (state == ST_IDLE) && start && !abort;
    // A word counts only while locked; the cycle lock drops is discarded.
    assign word_ok  = (state == ST_RUN) && chk_valid && chk_locked;

    // One extra carry bit detects overflow so the error count sticks at all-ones.
    assign err_wide = {1'b0, err_count} + (CNT_W + 1)'(err_bits);
    assign err_sum  = err_wide[CNT_W] ? '1 : err_wide[CNT_W-1:0];

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nxt     = state;
        set_timeout   = 1'b0;
        set_lock_lost = 1'b0;
        gen_reset     = 1'b0;
        gen_en        = 1'b0;
        chk_resync    = 1'b0;
        case (state)
            ST_IDLE: begin
                gen_reset = 1'b1;
                if (start_ok) state_nxt = ST_INIT;
            end
            ST_INIT: begin
                gen_reset  = 1'b1;
                chk_resync = 1'b1;
                state_nxt  = abort ? ST_DONE : ST_ACQ;
            end
            ST_ACQ: begin
                gen_en = 1'b1;
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (chk_locked) begin
                    state_nxt = ST_RUN;
                end else if (lock_timer == LT_W'(LOCK_TO - 1)) begin
                    set_timeout = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_RUN: begin
                gen_en = 1'b1;
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (!chk_locked) begin
                    set_lock_lost = 1'b1;
                    state_nxt     = ST_DONE;
                end else if (chk_valid && (win_q != '0) &&
                             (word_cnt + WIN_W'(1) == win_q)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            win_q      <= '0;
            word_cnt   <= '0;
            lock_timer <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            lock_lost  <= 1'b0;
            bit_count  <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            done       <= (state == ST_DONE);
            // Timer runs only in ACQ so every acquisition starts from zero.
            lock_timer <= (state == ST_ACQ) ? lock_timer + LT_W'(1) : '0;
            if (start_ok) begin
                win_q     <= win_words;
                word_cnt  <= '0;
                bit_count <= '0;
                err_count <= '0;
                timeout   <= 1'b0;
                lock_lost <= 1'b0;
            end else begin
                if (set_timeout)   timeout   <= 1'b1;
                if (set_lock_lost) lock_lost <= 1'b1;
                if (word_ok) begin
                    word_cnt  <= word_cnt + WIN_W'(1);
                    bit_count <= bit_count + CNT_W'(WIDTH);
                    err_count <= err_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_ber_test_ctrl.sv
// tb_ber_test_ctrl: directed bench for ber_test_ctrl. Two instances share
// the stimulus: the default 48-bit build and an 8-bit accumulator build
// that exercises error-count saturation and bit-count wrap.
module tb_ber_test_ctrl;
    import ber_pkg::*;

    localparam int WIDTH   = 32;
    localparam int WIN_W   = 32;
    localparam int LOCK_TO = 1024;

    typedef enum int {P_IDLE, P_INIT, P_ACQ, P_RUN, P_DONE} phase_e;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, start, abort, chk_locked, chk_valid;
    logic [WIN_W-1:0] win_words;
    logic [WIDTH-1:0] chk_err;

    logic        gen_reset, gen_en, chk_resync, busy, done, timeout, lock_lost;
    logic [47:0] bit_count, err_count;
    ber_state_e  state_dbg;
    logic        gen_reset8, gen_en8, chk_resync8, busy8, done8, timeout8, lock_lost8;
    logic [7:0]  bit_count8, err_count8;
    ber_state_e  state_dbg8;

    ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(48), .WIN_W(WIN_W), .LOCK_TO(LOCK_TO)) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .win_words(win_words),
        .chk_locked(chk_locked), .chk_valid(chk_valid), .chk_err(chk_err),
        .gen_reset(gen_reset), .gen_en(gen_en), .chk_resync(chk_resync), .busy(busy),
        .done(done), .timeout(timeout), .lock_lost(lock_lost),
        .bit_count(bit_count), .err_count(err_count), .state_dbg(state_dbg)
    );

    ber_test_ctrl #(.WIDTH(WIDTH), .CNT_W(8), .WIN_W(WIN_W), .LOCK_TO(LOCK_TO)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .win_words(win_words),
        .chk_locked(chk_locked), .chk_valid(chk_valid), .chk_err(chk_err),
        .gen_reset(gen_reset8), .gen_en(gen_en8), .chk_resync(chk_resync8), .busy(busy8),
        .done(done8), .timeout(timeout8), .lock_lost(lock_lost8),
        .bit_count(bit_count8), .err_count(err_count8), .state_dbg(state_dbg8)
    );

    // ---------------- model ----------------
    int              n_checks = 0;
    int              n_errors = 0;
    bit              chk_en = 1'b0;
    phase_e          exp_phase = P_IDLE;
    bit              exp_done = 1'b0;
    bit              exp_timeout = 1'b0;
    bit              exp_lock_lost = 1'b0;
    longint unsigned tot_bits = 0;
    longint unsigned tot_errs = 0;

    function automatic logic [63:0] sat(input longint unsigned v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (v > m) ? m : v;
    endfunction

    function automatic logic [63:0] wrap(input longint unsigned v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return v & m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("gen_reset",  gen_reset,  exp_phase == P_IDLE || exp_phase == P_INIT);
            check("gen_en",     gen_en,     exp_phase == P_ACQ  || exp_phase == P_RUN);
            check("chk_resync", chk_resync, exp_phase == P_INIT);
            check("busy",       busy,       exp_phase != P_IDLE);
            check("idle_state", state_dbg == ST_IDLE, exp_phase == P_IDLE);
            check("done",       done,       exp_done);
            check("timeout",    timeout,    exp_timeout);
            check("lock_lost",  lock_lost,  exp_lock_lost);
            check("bit_count",  bit_count,  wrap(tot_bits, 48));
            check("err_count",  err_count,  sat(tot_errs, 48));
            check("gen_reset8", gen_reset8, exp_phase == P_IDLE || exp_phase == P_INIT);
            check("gen_en8",    gen_en8,    exp_phase == P_ACQ  || exp_phase == P_RUN);
            check("chk_resync8", chk_resync8, exp_phase == P_INIT);
            check("busy8",      busy8,      exp_phase != P_IDLE);
            check("idle_state8", state_dbg8 == ST_IDLE, exp_phase == P_IDLE);
            check("done8",      done8,      exp_done);
            check("timeout8",   timeout8,   exp_timeout);
            check("lock_lost8", lock_lost8, exp_lock_lost);
            check("bit_count8", bit_count8, wrap(tot_bits, 8));
            check("err_count8", err_count8, sat(tot_errs, 8));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
    endtask

    task automatic clear_model();
        tot_bits      = 0;
        tot_errs      = 0;
        exp_timeout   = 1'b0;
        exp_lock_lost = 1'b0;
    endtask

    // Accepted start: one INIT cycle, then ACQ. win_words is changed right
    // after acceptance so a design that reads it live ends at the wrong word.
    task automatic start_run(input logic [WIN_W-1:0] win);
        chk_locked = 1'b0;
        chk_valid  = 1'b0;
        start      = 1'b1;
        win_words  = win;
        tick();
        exp_phase = P_INIT;
        clear_model();
        start     = 1'b0;
        win_words = 32'd7;
        tick();
        exp_phase = P_ACQ;
    endtask

    // Stay unlocked for n ACQ cycles (garbage words are offered and must be
    // ignored), then assert lock.
    task automatic acquire(input int n);
        chk_valid = 1'b1;
        chk_err   = '1;
        repeat (n) begin
            tick();
            exp_phase = P_ACQ;
        end
        chk_locked = 1'b1;
        tick();
        exp_phase = P_RUN;
        chk_valid = 1'b0;
        chk_err   = '0;
    endtask

    task automatic send_word(input bit v, input logic [WIDTH-1:0] e, input bit last);
        chk_valid = v;
        chk_err   = e;
        tick();
        if (v) begin
            tot_bits += WIDTH;
            tot_errs += $countones(e);
        end
        exp_phase = last ? P_DONE : P_RUN;
        chk_valid = 1'b0;
        chk_err   = '0;
    endtask

    task automatic finish_run();
        tick();
        exp_phase = P_IDLE;
        exp_done  = 1'b1;
        tick();
        repeat (2) tick();
    endtask

    // Global time bound: a hung bench reports and stops.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; win_words = '0;
        chk_locked = 1'b0; chk_valid = 1'b0; chk_err = '0;
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("rst_gen_reset", gen_reset, 1'b1);
        check("rst_bits", bit_count, 48'd0);

        // Run 1: 100-word window, error-free.
        start_run(32'd100);
        acquire(4);
        for (int i = 0; i < 100; i++) send_word(1'b1, '0, i == 99);
        finish_run();
        check("r1_bits", bit_count, 48'd3200);
        check("r1_errs", err_count, 48'd0);
        check("r1_timeout", timeout, 1'b0);

        // Run 2: 10 words of 2 errors, 1 word of 32 errors, idle gaps with garbage.
        start_run(32'd100);
        acquire(2);
        for (int i = 0; i < 100; i++) begin
            if (i % 7 == 3) send_word(1'b0, 32'hFFFF_0000, 1'b0);
            send_word(1'b1, (i < 10) ? 32'h0000_0101 : (i == 50) ? 32'hFFFF_FFFF : 32'h0, i == 99);
        end
        finish_run();
        check("r2_bits", bit_count, 48'd3200);
        check("r2_errs", err_count, 48'd52);
        check("r2_bits8", bit_count8, 8'd128);

        // Run 3: no lock, timeout after LOCK_TO ACQ cycles.
        start_run(32'd100);
        chk_locked = 1'b0;
        repeat (LOCK_TO - 1) begin
            tick();
            exp_phase = P_ACQ;
        end
        tick();
        exp_phase   = P_DONE;
        exp_timeout = 1'b1;
        finish_run();
        check("r3_timeout", timeout, 1'b1);
        check("r3_bits", bit_count, 48'd0);

        // Run 4: open window, 50 words, then lock drops (that word discarded).
        start_run(32'd0);
        acquire(3);
        for (int i = 0; i < 50; i++) send_word(1'b1, 32'h0000_0001, 1'b0);
        chk_locked = 1'b0;
        chk_valid  = 1'b1;
        chk_err    = '1;
        tick();
        exp_phase     = P_DONE;
        exp_lock_lost = 1'b1;
        chk_valid     = 1'b0;
        finish_run();
        check("r4_lock_lost", lock_lost, 1'b1);
        check("r4_bits", bit_count, 48'd1600);
        check("r4_errs", err_count, 48'd50);

        // Run 5: open window, abort on word 50 (counted); start in RUN ignored.
        start_run(32'd0);
        acquire(3);
        for (int i = 0; i < 49; i++) begin
            start = (i == 20);
            send_word(1'b1, '0, 1'b0);
            start = 1'b0;
        end
        abort = 1'b1;
        send_word(1'b1, 32'h0000_0003, 1'b1);
        abort = 1'b0;
        finish_run();
        check("r5_lock_lost", lock_lost, 1'b0);
        check("r5_bits", bit_count, 48'd1600);
        check("r5_errs", err_count, 48'd2);

        // Run 6: all-error words saturate the 8-bit error count.
        start_run(32'd0);
        acquire(1);
        for (int i = 0; i < 10; i++) send_word(1'b1, '1, 1'b0);
        abort = 1'b1;
        send_word(1'b0, '0, 1'b1);
        abort = 1'b0;
        finish_run();
        check("r6_errs", err_count, 48'd320);
        check("r6_errs8", err_count8, 8'd255);
        check("r6_bits8", bit_count8, 8'd64);
        // start together with abort in IDLE: ignored, counts kept.
        start = 1'b1; abort = 1'b1; win_words = 32'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        check("r6_hold_errs8", err_count8, 8'd255);
        check("r6_hold_busy", busy, 1'b0);

        // Run 7: abort in ACQ ends the run with no flags.
        start_run(32'd0);
        abort = 1'b1;
        tick();
        exp_phase = P_DONE;
        abort = 1'b0;
        finish_run();
        check("r7_timeout", timeout, 1'b0);

        // Run 8: reset mid-run returns to reset values with no done pulse.
        start_run(32'd0);
        acquire(0);
        for (int i = 0; i < 3; i++) send_word(1'b1, 32'h0000_0001, 1'b0);
        check("r8_bits", bit_count, 48'd96);
        reset = 1'b1;
        tick();
        exp_phase = P_IDLE;
        clear_model();
        reset = 1'b0;
        chk_locked = 1'b0;
        repeat (3) tick();
        check("r8_bits_rst", bit_count, 48'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
